fetch_pc_unit: RTL and testbench
================================

FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 SHALL have parameter QDEPTH, default 4, meaning the number of in-flight prediction records (power of two, 2..16).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port stallF, input, 1 bit: hold the fetch PC.
REQ-006 SHALL have port found, input, 1 bit: BTB hit for branching_addressF.
REQ-007 SHALL have port predictPC, input, 32 bits: BTB predicted target.
REQ-008 SHALL have port bp_state, input, 2 bits: BTB 2-bit counter for the looked-up entry.
REQ-009 SHALL have ports exec_valid (input, 1), exec_is_branch (input, 1), exec_taken (input, 1) and exec_target (input, 32): in-order resolution of the oldest in-flight instruction.
REQ-010 SHALL have ports branching_addressF (output, 32), the current fetch PC, and access (output, 1), the BTB lookup enable.
REQ-011 SHALL have port flushD (output, 1): one-cycle pulse that squashes younger instructions.
REQ-012 SHALL have ports update (output, 1), branchUpdatePC (output, 32) and branchUpdateTarget (output, 32): the BTB write request.
REQ-013 SHALL have ports queue_full (output, 1) and underflow_err (output, 1, sticky).

Function
REQ-014 pred_taken SHALL equal found AND bp_state[1].
REQ-015 access SHALL equal NOT reset AND NOT queue_full.
REQ-016 A push SHALL occur when access, NOT stallF and NOT mispredict; it records {pc, pred_taken, pred_target = predictPC} at the tail.
REQ-017 A pop SHALL occur when exec_valid and the queue is non-empty; it compares against the head record.
REQ-018 mispredict SHALL be asserted on a pop when any of the following holds:
- exec_is_branch and exec_taken differs from pred_taken;
- exec_is_branch, exec_taken and exec_target differs from pred_target;
- NOT exec_is_branch and pred_taken.
REQ-019 Next-PC priority SHALL be:
- reset -> RESET_PC;
- mispredict -> (exec_taken AND exec_is_branch) ? exec_target : head.pc+4;
- stallF or queue_full -> hold;
- pred_taken -> predictPC;
- otherwise pc+4.
REQ-020 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
REQ-021 On mispredict the queue SHALL be cleared next cycle, no push that cycle, and flushD pulses high for exactly the following cycle.
REQ-022 On a pop with exec_is_branch, update SHALL pulse one cycle later with branchUpdatePC = head.pc and branchUpdateTarget = exec_target.
REQ-023 With update low, branchUpdatePC and branchUpdateTarget SHALL hold their last values.
REQ-024 On a simultaneous push and pop with no mispredict, the count SHALL be unchanged and the pointers SHALL advance with wrap at QDEPTH.
REQ-025 queue_full SHALL equal (count == QDEPTH); a pop when full frees a slot for the next cycle, not the same cycle.
REQ-026 exec_valid while the queue is empty SHALL be ignored and SHALL set underflow_err until reset.
REQ-027 Latency SHALL be: prediction redirect 1 cycle; mispredict redirect 1 cycle; BTB update 1 cycle after resolution.

Reset
REQ-028 On reset: branching_addressF=RESET_PC, count=0, pointers=0, flushD=0, update=0, branchUpdatePC=0, branchUpdateTarget=0, underflow_err=0.
REQ-029 Reset asserted mid-operation SHALL discard pending flush/update pulses and all records in the same edge.

Structure
REQ-030 The shared package SHALL hold the record typedef {pc[31:0], pred_taken, pred_target[31:0]}, the PC increment constant 4 and the BTB counter encodings N/NT/TN/T.
REQ-031 The record queue SHALL be one sub-module, pred_queue (synchronous FIFO with push/pop/clear/count); the next-PC logic stays in the top.

Verification
REQ-032 Reset, then no stall, found=0 for 3 cycles -> PC sequence 0, 4, 8, 12; access=1.
REQ-033 At PC=8, found=1, bp_state=2'b11, predictPC=32'h40 -> next PC 32'h40; exec branch taken to 32'h40 -> no flushD; update=1 with PC 8, target 32'h40.
REQ-034 Predicted taken at PC=8, resolved exec_taken=0 -> flushD pulse for 1 cycle, next PC 12, queue count 0.
REQ-035 exec_valid=0 with 4 pushes -> queue_full=1, access=0, PC held; one pop -> queue_full=0 the next cycle.
REQ-036 exec_valid=1 with the queue empty -> underflow_err=1 until reset; a mispredict in the same cycle as reset -> no flushD, PC=RESET_PC.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// Shared types and constants for the fetch PC unit: prediction record,
// PC increment and the BTB 2-bit counter encodings.
package fetch_pc_unit_pkg;

    localparam logic [31:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        BP_N  = 2'b00,
        BP_NT = 2'b01,
        BP_TN = 2'b10,
        BP_T  = 2'b11
    } bp_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] pred_target;
    } pred_rec_t;

    // Only the taken-side counter states redirect fetch.
    function automatic logic predicts_taken(input logic found, input logic [1:0] bp_state);
        return found && (bp_state == BP_TN || bp_state == BP_T);
    endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Bundle of BTB lookup/update, execute resolution and status signals
// between the fetch PC unit (master) and its environment (slave).
interface fetch_pc_unit_if;
    import fetch_pc_unit_pkg::*;

    logic        stallF;
    logic        found;
    logic [31:0] predictPC;
    logic [1:0]  bp_state;
    logic        exec_valid;
    logic        exec_is_branch;
    logic        exec_taken;
    logic [31:0] exec_target;
    logic [31:0] branching_addressF;
    logic        access;
    logic        flushD;
    logic        update;
    logic [31:0] branchUpdatePC;
    logic [31:0] branchUpdateTarget;
    logic        queue_full;
    logic        underflow_err;

    modport master (
        input  stallF, found, predictPC, bp_state,
        input  exec_valid, exec_is_branch, exec_taken, exec_target,
        output branching_addressF, access, flushD,
        output update, branchUpdatePC, branchUpdateTarget,
        output queue_full, underflow_err
    );

    modport slave (
        output stallF, found, predictPC, bp_state,
        output exec_valid, exec_is_branch, exec_taken, exec_target,
        input  branching_addressF, access, flushD,
        input  update, branchUpdatePC, branchUpdateTarget,
        input  queue_full, underflow_err
    );

endinterface

// File: rtl/fetch_pc_unit_pred_queue.sv
// In-flight prediction records, oldest at head; push/pop/clear in one cycle.
// Caller guarantees no push when full and no pop when empty.
module pred_queue
    import fetch_pc_unit_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic                      pop,
    input  logic                      clear,
    input  pred_rec_t                 din,
    output pred_rec_t                 head,
    output logic [$clog2(QDEPTH):0]   count
);
    localparam int AW = $clog2(QDEPTH);

    pred_rec_t     mem [QDEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign head = mem[rd_ptr];

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC generation with BTB prediction, in-order resolution and redirect.
// Redirects and BTB updates take effect one cycle after the deciding edge.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4
) (
    input  logic             clk,
    input  logic             reset,
    fetch_pc_unit_if.master  bus
);
    localparam int CW = $clog2(QDEPTH) + 1;

    logic [31:0]   pc;
    logic [31:0]   pc_next;
    logic [CW-1:0] q_count;
    logic          q_full;
    logic          q_empty;
    logic          pred_taken;
    logic          push;
    logic          pop;
    logic          mispredict;
    pred_rec_t     head;
    pred_rec_t     push_rec;

    logic          flush_q;
    logic          update_q;
    logic [31:0]   upd_pc_q;
    logic [31:0]   upd_target_q;
    logic          underflow_q;

    assign pred_taken = predicts_taken(bus.found, bus.bp_state);
    assign q_full     = (q_count == CW'(QDEPTH));
    assign q_empty    = (q_count == '0);
    assign pop        = bus.exec_valid && !q_empty;
    assign push       = bus.access && !bus.stallF && !mispredict;
    assign push_rec   = '{pc: pc, pred_taken: pred_taken, pred_target: bus.predictPC};

    always_comb begin
        mispredict = 1'b0;
        if (pop) begin
            if (bus.exec_is_branch) begin
                mispredict = (bus.exec_taken != head.pred_taken) ||
                             (bus.exec_taken && (bus.exec_target != head.pred_target));
            end else begin
                mispredict = head.pred_taken;
            end
        end
    end

    always_comb begin
        pc_next = pc + PC_INC;
        if (mispredict) begin
            pc_next = (bus.exec_is_branch && bus.exec_taken) ? bus.exec_target
                                                             : head.pc + PC_INC;
        end else if (bus.stallF || q_full) begin
            pc_next = pc;
        end else if (pred_taken) begin
            pc_next = bus.predictPC;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= RESET_PC;
            flush_q      <= 1'b0;
            update_q     <= 1'b0;
            upd_pc_q     <= '0;
            upd_target_q <= '0;
            underflow_q  <= 1'b0;
        end else begin
            pc       <= pc_next;
            flush_q  <= mispredict;
            update_q <= pop && bus.exec_is_branch;
            if (pop && bus.exec_is_branch) begin
                upd_pc_q     <= head.pc;
                upd_target_q <= bus.exec_target;
            end
            if (bus.exec_valid && q_empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    pred_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clear (mispredict),
        .din   (push_rec),
        .head  (head),
        .count (q_count)
    );

    assign bus.branching_addressF = pc;
    assign bus.access             = !reset && !q_full;
    assign bus.queue_full         = q_full;
    assign bus.flushD             = flush_q;
    assign bus.update             = update_q;
    assign bus.branchUpdatePC     = upd_pc_q;
    assign bus.branchUpdateTarget = upd_target_q;
    assign bus.underflow_err      = underflow_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: sequencing, prediction, mispredict
// redirect, queue full/wrap, underflow and reset-during-mispredict.
module tb_fetch_pc_unit;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    fetch_pc_unit_if bus ();

    fetch_pc_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stallF         = 1'b0;
        bus.found          = 1'b0;
        bus.predictPC      = 32'h0;
        bus.bp_state       = 2'b00;
        bus.exec_valid     = 1'b0;
        bus.exec_is_branch = 1'b0;
        bus.exec_taken     = 1'b0;
        bus.exec_target    = 32'h0;
    endtask

    task automatic set_exec(input logic v, input logic br, input logic tk, input logic [31:0] tgt);
        bus.exec_valid     = v;
        bus.exec_is_branch = br;
        bus.exec_taken     = tk;
        bus.exec_target    = tgt;
    endtask

    task automatic set_btb(input logic f, input logic [1:0] st, input logic [31:0] tgt);
        bus.found     = f;
        bus.bp_state  = st;
        bus.predictPC = tgt;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        check_eq("rst_pc", bus.branching_addressF, 32'h0);
        check_eq("rst_flushD", bus.flushD, 0);
        check_eq("rst_update", bus.update, 0);
        check_eq("rst_upd_pc", bus.branchUpdatePC, 32'h0);
        check_eq("rst_upd_tgt", bus.branchUpdateTarget, 32'h0);
        check_eq("rst_underflow", bus.underflow_err, 0);
        check_eq("rst_access", bus.access, 0);
        check_eq("rst_qfull", bus.queue_full, 0);
        check_eq("rst_count", dut.u_queue.count, 0);
        reset = 1'b0;
        #1;
        check_eq("seq_access", bus.access, 1);

        // Sequential fetch
        tick(); check_eq("seq_pc4", bus.branching_addressF, 32'd4);
        tick(); check_eq("seq_pc8", bus.branching_addressF, 32'd8);
        tick(); check_eq("seq_pc12", bus.branching_addressF, 32'd12);

        // Correct taken prediction, BTB update one cycle after resolution
        do_reset();
        tick(); tick();
        set_btb(1'b1, 2'b11, 32'h40);
        tick(); check_eq("pred_pc", bus.branching_addressF, 32'h40);
        set_btb(1'b0, 2'b00, 32'h0);
        set_exec(1'b1, 1'b0, 1'b0, 32'h0);
        tick(); check_eq("nb_pop_pc", bus.branching_addressF, 32'h44);
        check_eq("nb_pop_update", bus.update, 0);
        tick();
        set_exec(1'b1, 1'b1, 1'b1, 32'h40);
        tick();
        check_eq("hit_flushD", bus.flushD, 0);
        check_eq("hit_update", bus.update, 1);
        check_eq("hit_upd_pc", bus.branchUpdatePC, 32'd8);
        check_eq("hit_upd_tgt", bus.branchUpdateTarget, 32'h40);
        check_eq("hit_pc", bus.branching_addressF, 32'h4c);
        set_exec(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check_eq("upd_pulse_end", bus.update, 0);
        check_eq("upd_pc_hold", bus.branchUpdatePC, 32'd8);
        check_eq("upd_tgt_hold", bus.branchUpdateTarget, 32'h40);

        // Weak not-taken, weak taken to top of memory, wrap, stall
        do_reset();
        set_btb(1'b1, 2'b01, 32'h80);
        tick(); check_eq("weak_nt_pc", bus.branching_addressF, 32'd4);
        set_btb(1'b1, 2'b10, 32'hFFFF_FFFC);
        tick(); check_eq("weak_t_pc", bus.branching_addressF, 32'hFFFF_FFFC);
        set_btb(1'b0, 2'b00, 32'h0);
        tick(); check_eq("wrap_pc", bus.branching_addressF, 32'h0);
        bus.stallF = 1'b1;
        tick(); check_eq("stall_pc", bus.branching_addressF, 32'h0);
        check_eq("stall_count", dut.u_queue.count, 3);
        bus.stallF = 1'b0;

        // Predicted taken, resolved not taken
        do_reset();
        tick(); tick();
        set_btb(1'b1, 2'b11, 32'h40);
        tick();
        set_btb(1'b0, 2'b00, 32'h0);
        set_exec(1'b1, 1'b0, 1'b0, 32'h0);
        tick(); tick();
        check_eq("mp_pre_count", dut.u_queue.count, 3);
        set_exec(1'b1, 1'b1, 1'b0, 32'h40);
        tick();
        check_eq("mp_flushD", bus.flushD, 1);
        check_eq("mp_pc", bus.branching_addressF, 32'd12);
        check_eq("mp_count", dut.u_queue.count, 0);
        check_eq("mp_update", bus.update, 1);
        check_eq("mp_upd_pc", bus.branchUpdatePC, 32'd8);
        set_exec(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check_eq("mp_flush_end", bus.flushD, 0);
        check_eq("mp_pc_next", bus.branching_addressF, 32'd16);
        check_eq("mp_count_next", dut.u_queue.count, 1);

        // Predicted not taken, resolved taken
        set_exec(1'b1, 1'b1, 1'b1, 32'h100);
        tick();
        check_eq("mp_nt_pc", bus.branching_addressF, 32'h100);
        check_eq("mp_nt_flushD", bus.flushD, 1);
        set_exec(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check_eq("mp_nt_flush_end", bus.flushD, 0);

        // Non-branch that was predicted taken
        set_btb(1'b1, 2'b11, 32'h500);
        set_exec(1'b1, 1'b0, 1'b0, 32'h0);
        tick(); check_eq("nbp_pred_pc", bus.branching_addressF, 32'h500);
        set_btb(1'b0, 2'b00, 32'h0);
        tick();
        check_eq("nbp_pc", bus.branching_addressF, 32'h108);
        check_eq("nbp_flushD", bus.flushD, 1);
        check_eq("nbp_update", bus.update, 0);

        // Queue full, pop frees a slot next cycle, pointer wrap
        do_reset();
        repeat (4) tick();
        check_eq("full_pc", bus.branching_addressF, 32'd16);
        check_eq("full_flag", bus.queue_full, 1);
        check_eq("full_access", bus.access, 0);
        tick(); check_eq("full_hold_pc", bus.branching_addressF, 32'd16);
        set_exec(1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        check_eq("full_same_cycle", bus.queue_full, 1);
        tick();
        check_eq("full_freed", bus.queue_full, 0);
        check_eq("full_freed_pc", bus.branching_addressF, 32'd16);
        tick(); tick(); tick();
        check_eq("wrap_fetch_pc", bus.branching_addressF, 32'd28);
        set_exec(1'b1, 1'b1, 1'b1, 32'h200);
        tick();
        check_eq("wrap_mp_pc", bus.branching_addressF, 32'h200);
        check_eq("wrap_upd_pc", bus.branchUpdatePC, 32'd16);
        check_eq("wrap_upd_tgt", bus.branchUpdateTarget, 32'h200);
        set_exec(1'b0, 1'b0, 1'b0, 32'h0);

        // Underflow is sticky; reset overrides a same-cycle mispredict
        do_reset();
        set_exec(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        check_eq("uf_set", bus.underflow_err, 1);
        check_eq("uf_pc", bus.branching_addressF, 32'd4);
        check_eq("uf_update", bus.update, 0);
        set_exec(1'b0, 1'b0, 1'b0, 32'h0);
        tick(); tick();
        check_eq("uf_sticky", bus.underflow_err, 1);
        set_exec(1'b1, 1'b1, 1'b1, 32'h300);
        reset = 1'b1;
        tick();
        check_eq("rmp_pc", bus.branching_addressF, 32'h0);
        check_eq("rmp_flushD", bus.flushD, 0);
        check_eq("rmp_update", bus.update, 0);
        check_eq("rmp_underflow", bus.underflow_err, 0);
        check_eq("rmp_count", dut.u_queue.count, 0);
        idle_inputs();
        reset = 1'b0;
        #1;
        tick();
        check_eq("rmp_after_flushD", bus.flushD, 0);
        check_eq("rmp_after_pc", bus.branching_addressF, 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
